// File: rtl/hmmm_pkg.sv
// hmmm_pkg: shared widths and program-loader state encoding for the hmmm core
package hmmm_pkg;
    localparam int HMMM_DATA_W = 16;
    localparam int HMMM_ADDR_W = 8;
    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RELEASE, ST_RUN} ld_state_e;
endpackage

// File: rtl/hmmm_start_timer.sv
// hmmm_start_timer: loadable down-counter that flags zero, times the hold release
module hmmm_start_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         zero
);
    logic [W-1:0] cnt_q, cnt_d;

    assign zero = (cnt_q == '0);

    // load wins over counting; the counter parks at zero instead of wrapping
    always_comb begin
        cnt_d = load ? load_val : (en && !zero) ? cnt_q - W'(1) : cnt_q;
    end

    // counter register, cleared by active-low async reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/hmmm_prog_loader.sv
// hmmm_prog_loader: sequenced instruction loader and core hold/release; HMMM_LOAD_CSUM_EN adds a write checksum output
module hmmm_prog_loader
    import hmmm_pkg::*;
#(
    parameter int DATA_W    = HMMM_DATA_W,
    parameter int ADDR_W    = HMMM_ADDR_W,
    parameter int DEPTH     = 256,
    parameter int START_DLY = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pgrm_addr,
    input  logic              pgrm_data,
    input  logic              pgrm_auto,
    input  logic              pgrm_done,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              cpu_halt,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              err,
    output logic              wrapped,
`ifdef HMMM_LOAD_CSUM_EN
    output logic [DATA_W-1:0] csum,
`endif
    output logic [ADDR_W:0]   load_cnt
);
    localparam int TW = $clog2(START_DLY + 1);

    ld_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d, err_q, err_d, wrapped_q, wrapped_d;
    logic [ADDR_W:0]   load_cnt_q, load_cnt_d, cnt_base;
    logic              strobe, accept, clr, wr, lat, start, at_end, in_range, tmr_zero;

    // widen before comparing so an out-of-range host word is never truncated into range
    assign in_range = (DATA_W + 32)'(bus_in) < (DATA_W + 32)'(DEPTH);

    hmmm_start_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (start),
        .en       (state_q == ST_RELEASE),
        .load_val (TW'(START_DLY)),
        .zero     (tmr_zero)
    );

    // strobe qualification, next state and all register next-values
    always_comb begin
        strobe      = pgrm_addr | pgrm_data;
        accept      = strobe & (state_q == ST_IDLE || state_q == ST_LOAD || (state_q == ST_RUN && cpu_halt));
        clr         = strobe & (state_q == ST_IDLE || (state_q == ST_RUN && cpu_halt));
        wr          = accept & pgrm_data & ~pgrm_addr;
        lat         = accept & pgrm_addr & ~pgrm_data;
        start       = pgrm_done & (state_q == ST_IDLE || state_q == ST_LOAD);
        at_end      = (addr_q == ADDR_W'(DEPTH - 1));
        state_d     = start ? ST_RELEASE : accept ? ST_LOAD :
                      (state_q == ST_RELEASE && tmr_zero) ? ST_RUN : state_q;
        err_d       = (clr ? 1'b0 : err_q) | (strobe & ~accept) | (accept & pgrm_addr & pgrm_data) | (lat & ~in_range);
        wrapped_d   = (clr ? 1'b0 : wrapped_q) | (wr & pgrm_auto & at_end);
        addr_d      = (lat && in_range) ? bus_in[ADDR_W-1:0] :
                      (wr && pgrm_auto) ? (at_end ? '0 : addr_q + ADDR_W'(1)) : addr_q;
        cnt_base    = clr ? '0 : load_cnt_q;
        load_cnt_d  = cnt_base + {{ADDR_W{1'b0}}, wr & (cnt_base != '1)};
        mem_we_d    = wr;
        mem_addr_d  = wr ? addr_q : mem_addr_q;
        mem_wdata_d = wr ? bus_in : mem_wdata_q;
    end

    // loader state and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            err_q       <= 1'b0;
            wrapped_q   <= 1'b0;
            load_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            err_q       <= err_d;
            wrapped_q   <= wrapped_d;
            load_cnt_q  <= load_cnt_d;
        end
    end

`ifdef HMMM_LOAD_CSUM_EN
    logic [DATA_W-1:0] csum_q, csum_d;

    // sums words as they reach the memory port; restarts with each new load session
    always_comb begin
        csum_d = clr ? '0 : csum_q + (mem_we_q ? mem_wdata_q : '0);
    end

    // checksum register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) csum_q <= '0;
        else      csum_q <= csum_d;
    end

    assign csum = csum_q;
`endif

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_hold  = (state_q != ST_RUN);
    assign busy      = (state_q == ST_LOAD || state_q == ST_RELEASE);
    assign err       = err_q;
    assign wrapped   = wrapped_q;
    assign load_cnt  = load_cnt_q;
endmodule

// File: doc/hmmm_prog_loader.md
Name: hmmm_prog_loader

Overview:
- Parametrised program-load controller for the hmmm core. It replaces the single-word pgrm_addr/pgrm_data strobe protocol with a sequenced loader.
- Adds a latched address, auto-increment burst mode, range and protocol error checks, and a CPU hold/release sequence with a programmable start delay.
- Sits between the host-driven shared bus and the instruction-memory write port plus the core reset input.

Parameters:
- DATA_W, 16, instruction/bus word width.
- ADDR_W, 8, memory address width.
- DEPTH, 256, number of valid words; must be ≤ 2**ADDR_W.
- START_DLY, 4, cycles between pgrm_done and hold release; must be ≥ 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- pgrm_addr  in  1  strobe: latch bus_in as load address.
- pgrm_data  in  1  strobe: write bus_in as instruction word.
- pgrm_auto  in  1  1 = post-increment address after each data write.
- pgrm_done  in  1  pulse: loading finished, start release countdown.
- bus_in  in  DATA_W  host word on shared bus.
- cpu_halt  in  1  core halt status.
- mem_we  out  1  instruction-memory write enable, one-cycle pulse.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  DATA_W  write data.
- cpu_hold  out  1  holds core in reset while high.
- busy  out  1  high in LOAD or RELEASE.
- err  out  1  sticky protocol/range error.
- wrapped  out  1  sticky: auto-increment wrapped DEPTH-1 → 0.
- load_cnt  out  ADDR_W+1  words written since last entry to LOAD.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; cpu_hold=1; mem_we=0; mem_addr=0; mem_wdata=0.
  - busy=0; err=0; wrapped=0; load_cnt=0; delay counter=0.
- States: IDLE, LOAD, RELEASE, RUN.
- IDLE:
  - First pgrm_addr or pgrm_data → LOAD. That strobe is processed in the same cycle.
  - pgrm_done → RELEASE with no words loaded.
- RUN:
  - cpu_hold=0.
  - A strobe with cpu_halt=1 → LOAD, and the strobe is processed. On entry to LOAD, cpu_hold=1 next cycle, and load_cnt, err and wrapped clear.
  - A strobe with cpu_halt=0 is ignored and sets err.
- pgrm_addr (IDLE/LOAD, sampled at clk):
  - addr_reg ← bus_in[ADDR_W-1:0] at the edge.
  - If bus_in value ≥ DEPTH: err←1 and addr_reg is unchanged.
- pgrm_data (IDLE/LOAD):
  - Next cycle, mem_we=1 for exactly one cycle with mem_addr=addr_reg and mem_wdata=bus_in. Latency is 1 cycle from strobe to write.
  - load_cnt increments, saturating at 2**(ADDR_W+1)-1.
  - If pgrm_auto=1: addr_reg ← addr_reg+1, or ← 0 with wrapped←1 when addr_reg=DEPTH-1.
- pgrm_addr and pgrm_data in the same cycle: no latch, no write, err←1.
- Back-to-back pgrm_data on consecutive cycles is legal; one write per cycle.
- LOAD + pgrm_done:
  - → RELEASE and the counter loads START_DLY.
  - Strobes in the same cycle as pgrm_done are processed; later strobes in RELEASE are ignored and set err.
- RELEASE:
  - Counter decrements each cycle. At 0 → RUN and cpu_hold=0 on the following edge.
  - Total from pgrm_done to cpu_hold falling is START_DLY+1 cycles.
- busy = (state==LOAD || state==RELEASE).
- err and wrapped clear only on reset or on entry to LOAD from RUN/IDLE.
- Reset mid-LOAD or mid-RELEASE: immediate return to IDLE. Any pending mem_we is dropped, and cpu_hold is high asynchronously.

Optional Feature:
- HMMM_LOAD_CSUM_EN defined:
  - Extra output csum [DATA_W-1:0], a running modulo-2**DATA_W sum of every mem_wdata actually written.
  - Cleared on reset and on entry to LOAD; frozen outside LOAD.
- Undefined: port csum absent and no adder logic.

Decomposition:
- Package hmmm_pkg:
  - loader state enum (IDLE, LOAD, RELEASE, RUN).
  - default DATA_W/ADDR_W constants shared with the hmmm core.
- One sub-module: hmmm_start_timer, a loadable down-counter of width $clog2(START_DLY+1) with load, enable and zero outputs, used for RELEASE.

Test Plan:
- Single write: reset; pgrm_addr bus=0x0000; pgrm_data bus=0x112A → one mem_we pulse, mem_addr=0, mem_wdata=0x112A, load_cnt=1, err=0.
- Burst: pgrm_auto=1, address 0x00FE, three data strobes 0x1111/0x2222/0x3333 on consecutive cycles → writes at 0xFE, 0xFF, 0x00; wrapped=1; load_cnt=3.
- Range/collision: pgrm_addr with bus=0x0100 (DEPTH=256) → err=1 and addr unchanged; then pgrm_addr and pgrm_data together → no mem_we, err stays 1.
- Release: pgrm_done with START_DLY=4 → cpu_hold falls exactly 5 cycles later and busy falls at the same time; a data strobe during RELEASE → ignored, err=1.
- Reload gating: in RUN, pgrm_data with cpu_halt=0 → ignored, err=1; with cpu_halt=1 → LOAD, cpu_hold=1, write occurs, err/load_cnt cleared before counting.
- Reset mid-load: rst low during burst → cpu_hold=1, mem_we=0 immediately; with HMMM_LOAD_CSUM_EN, writes 0x0001 and 0xFFFF give csum=0x0000.
